// File: rtl/kmeans_centroid_update_k2_d3.sv
// ============================================================================
// kmeans_centroid_update_k2_d3 : per-centroid accumulate, restoring divide and
// commit of two 3-D centroids.                                   Revision 1.0
// ============================================================================
`default_nettype none

module kmeans_centroid_update_k2_d3 #(
   parameter int INPUT_DATA_WIDTH = 16,
   parameter int COUNT_WIDTH      = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [INPUT_DATA_WIDTH-1:0] input_data0,
   input  logic [INPUT_DATA_WIDTH-1:0] input_data1,
   input  logic [INPUT_DATA_WIDTH-1:0] input_data2,
   input  logic                        selected_centroid,
   input  logic                        in_last,
   input  logic                        load_en,
   input  logic                        load_k,
   input  logic [INPUT_DATA_WIDTH-1:0] load_d0,
   input  logic [INPUT_DATA_WIDTH-1:0] load_d1,
   input  logic [INPUT_DATA_WIDTH-1:0] load_d2,
   output logic [INPUT_DATA_WIDTH-1:0] centroid0_d0,
   output logic [INPUT_DATA_WIDTH-1:0] centroid0_d1,
   output logic [INPUT_DATA_WIDTH-1:0] centroid0_d2,
   output logic [INPUT_DATA_WIDTH-1:0] centroid1_d0,
   output logic [INPUT_DATA_WIDTH-1:0] centroid1_d1,
   output logic [INPUT_DATA_WIDTH-1:0] centroid1_d2,
   output logic                        busy,
   output logic                        update_done,
   output logic                        overflow
);

   localparam int SUM_WIDTH     = INPUT_DATA_WIDTH + COUNT_WIDTH;
   localparam int BIT_CNT_WIDTH = $clog2(SUM_WIDTH + 1);
   localparam logic [BIT_CNT_WIDTH-1:0] C_STORE_STEP = BIT_CNT_WIDTH'(SUM_WIDTH);
   localparam logic [COUNT_WIDTH-1:0]   C_COUNT_MAX  = '1;
   localparam logic [SUM_WIDTH-1:0]     C_MSB_ONE    = {1'b1, {(SUM_WIDTH-1){1'b0}}};
   localparam logic [2:0]               C_LAST_DIV   = 3'd5;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DIV    = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t                       state_q, state_d;
   logic [SUM_WIDTH-1:0]         sum_q [2][3];
   logic [SUM_WIDTH-1:0]         sum_d [2][3];
   logic [COUNT_WIDTH-1:0]       cnt_q [2];
   logic [COUNT_WIDTH-1:0]       cnt_d [2];
   logic [INPUT_DATA_WIDTH-1:0]  cent_q [2][3];
   logic [INPUT_DATA_WIDTH-1:0]  cent_d [2][3];
   logic [INPUT_DATA_WIDTH-1:0]  shadow_q [2][3];
   logic [INPUT_DATA_WIDTH-1:0]  shadow_d [2][3];
   logic                         overflow_q, overflow_d;
   logic [2:0]                   div_idx_q, div_idx_d;
   logic [BIT_CNT_WIDTH-1:0]     step_q, step_d;
   logic [COUNT_WIDTH-1:0]       rem_q, rem_d;
   logic [INPUT_DATA_WIDTH-1:0]  quo_q, quo_d;

   logic [INPUT_DATA_WIDTH-1:0]  w_in [3];
   logic                         w_cur_k;
   logic [1:0]                   w_cur_d;
   logic [SUM_WIDTH-1:0]         w_div_sum;
   logic [COUNT_WIDTH-1:0]       w_div_cnt;
   logic                         w_div_bit;
   logic [COUNT_WIDTH:0]         w_trial;
   logic                         w_ge;

   assign w_in[0] = input_data0;
   assign w_in[1] = input_data1;
   assign w_in[2] = input_data2;

   always_comb begin
      w_cur_k = 1'b0;
      w_cur_d = 2'd0;
      case (div_idx_q)
         3'd1:    w_cur_d = 2'd1;
         3'd2:    w_cur_d = 2'd2;
         3'd3:    w_cur_k = 1'b1;
         3'd4:    begin w_cur_k = 1'b1; w_cur_d = 2'd1; end
         3'd5:    begin w_cur_k = 1'b1; w_cur_d = 2'd2; end
         default: ;
      endcase
   end

   // One restoring step: dividend bits are consumed MSB first from the frozen sum.
   assign w_div_sum = sum_q[w_cur_k][w_cur_d];
   assign w_div_cnt = cnt_q[w_cur_k];
   assign w_div_bit = |(w_div_sum & (C_MSB_ONE >> step_q));
   assign w_trial   = {rem_q, w_div_bit};
   assign w_ge      = (w_trial >= {1'b0, w_div_cnt});

   always_comb begin
      state_d    = state_q;
      sum_d      = sum_q;
      cnt_d      = cnt_q;
      cent_d     = cent_q;
      shadow_d   = shadow_q;
      overflow_d = overflow_q;
      div_idx_d  = div_idx_q;
      step_d     = step_q;
      rem_d      = rem_q;
      quo_d      = quo_q;

      case (state_q)
         ACCUM: begin
            if (in_valid) begin
               if (cnt_q[selected_centroid] == C_COUNT_MAX) begin
                  overflow_d = 1'b1;
               end else begin
                  cnt_d[selected_centroid] = cnt_q[selected_centroid] + COUNT_WIDTH'(1);
                  for (int d = 0; d < 3; d++) begin
                     sum_d[selected_centroid][d] = sum_q[selected_centroid][d]
                                                   + SUM_WIDTH'(w_in[d]);
                  end
               end
               if (in_last) begin
                  state_d = DIV;
               end
            end
         end
         DIV: begin
            if (step_q != C_STORE_STEP) begin
               rem_d  = w_ge ? (w_trial[COUNT_WIDTH-1:0] - w_div_cnt) : w_trial[COUNT_WIDTH-1:0];
               quo_d  = {quo_q[INPUT_DATA_WIDTH-2:0], w_ge};
               step_d = step_q + BIT_CNT_WIDTH'(1);
            end else begin
               shadow_d[w_cur_k][w_cur_d] = (w_div_cnt == '0) ? cent_q[w_cur_k][w_cur_d] : quo_q;
               rem_d  = '0;
               quo_d  = '0;
               step_d = '0;
               if (div_idx_q == C_LAST_DIV) begin
                  div_idx_d  = 3'd0;
                  state_d    = COMMIT;
                  cent_d     = shadow_d;
                  overflow_d = 1'b0;
                  for (int k = 0; k < 2; k++) begin
                     cnt_d[k] = '0;
                     for (int d = 0; d < 3; d++) begin
                        sum_d[k][d] = '0;
                     end
                  end
               end else begin
                  div_idx_d = div_idx_q + 3'd1;
               end
            end
         end
         COMMIT: begin
            state_d = ACCUM;
         end
         default: begin
            state_d = ACCUM;
         end
      endcase

      if (load_en && (state_q != DIV)) begin
         cent_d[load_k][0] = load_d0;
         cent_d[load_k][1] = load_d1;
         cent_d[load_k][2] = load_d2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ACCUM;
         overflow_q <= 1'b0;
         div_idx_q  <= 3'd0;
         step_q     <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         for (int k = 0; k < 2; k++) begin
            cnt_q[k] <= '0;
            for (int d = 0; d < 3; d++) begin
               sum_q[k][d]    <= '0;
               cent_q[k][d]   <= '0;
               shadow_q[k][d] <= '0;
            end
         end
      end else begin
         state_q    <= state_d;
         overflow_q <= overflow_d;
         div_idx_q  <= div_idx_d;
         step_q     <= step_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         cnt_q      <= cnt_d;
         sum_q      <= sum_d;
         cent_q     <= cent_d;
         shadow_q   <= shadow_d;
      end
   end

   assign in_ready     = (state_q == ACCUM);
   assign busy         = (state_q == DIV);
   assign update_done  = (state_q == COMMIT);
   assign overflow     = overflow_q;
   assign centroid0_d0 = cent_q[0][0];
   assign centroid0_d1 = cent_q[0][1];
   assign centroid0_d2 = cent_q[0][2];
   assign centroid1_d0 = cent_q[1][0];
   assign centroid1_d1 = cent_q[1][1];
   assign centroid1_d2 = cent_q[1][2];

endmodule

`default_nettype wire
